// File: rtl/adc_capture_sequencer.sv
// Run-level sequencer for the ADC packetiser: arm/trigger, capture enable, frame counting, gap, watchdog.
// All outputs registered (1-cycle latency from inputs); observes stream backpressure only by snooping tvalid/tready.
module adc_capture_sequencer #(
   parameter int GAP_W = 16,
   parameter int TMO_W = 24,
   parameter int FRM_W = 16
) (
   input  logic             clk_i,
   input  logic             reset_ni,
   input  logic             start_i,
   input  logic             abort_i,
   input  logic             trig_i,
   input  logic             cfg_trig_en_i,
   input  logic [FRM_W-1:0] cfg_frames_i,
   input  logic [31:0]      cfg_length_i,
   input  logic [GAP_W-1:0] cfg_gap_i,
   input  logic [TMO_W-1:0] cfg_tmo_i,
   input  logic             mon_tvalid_i,
   input  logic             mon_tready_i,
   input  logic             mon_tlast_i,
   output logic             adc_capture_en_o,
   output logic [31:0]      length_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             timeout_o,
   output logic [FRM_W-1:0] frame_cnt_o
);

   typedef enum logic [2:0] {IDLE, ARM, CAPTURE, GAP, DONE} state_t;

   state_t           state, state_nxt;
   logic             beat, eop, trig_prev, trig_edge, wd_fire, last_frame;
   logic             en_nxt, busy_nxt, done_nxt;
   logic             trig_en;
   logic [FRM_W-1:0] frames, cnt_inc;
   logic [GAP_W-1:0] gap, gap_cnt;
   logic [TMO_W-1:0] tmo, wd_cnt;

   assign beat       = mon_tvalid_i & mon_tready_i;
   assign eop        = beat & mon_tlast_i;
   assign trig_edge  = trig_i & ~trig_prev;
   assign cnt_inc    = (frame_cnt_o == '1) ? frame_cnt_o : frame_cnt_o + FRM_W'(1);
   assign last_frame = (cnt_inc == frames);
   assign wd_fire    = (tmo != '0) && !beat && (wd_cnt == tmo - TMO_W'(1));

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) state <= IDLE;
      else           state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (state != IDLE && abort_i) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (start_i) state_nxt = ARM;
            ARM:     if (!trig_en || trig_edge) state_nxt = CAPTURE;
            CAPTURE: begin
               if (wd_fire)  state_nxt = IDLE;
               else if (eop) state_nxt = last_frame ? DONE : ((gap == '0) ? ARM : GAP);
            end
            GAP:     if (gap_cnt == gap - GAP_W'(1)) state_nxt = ARM;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Enable is held only until the first beat of a frame so the packetiser cannot re-arm after tlast.
   always_comb begin
      en_nxt = 1'b0;
      if (state == ARM)          en_nxt = (state_nxt == CAPTURE);
      else if (state == CAPTURE) en_nxt = adc_capture_en_o && !beat && (state_nxt == CAPTURE);
      busy_nxt = (state_nxt != IDLE);
      done_nxt = (state_nxt == DONE);
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         adc_capture_en_o <= 1'b0;
         length_o         <= '0;
         busy_o           <= 1'b0;
         done_o           <= 1'b0;
         timeout_o        <= 1'b0;
         frame_cnt_o      <= '0;
         trig_prev        <= 1'b1;
         trig_en          <= 1'b0;
         frames           <= '0;
         gap              <= '0;
         tmo              <= '0;
         gap_cnt          <= '0;
         wd_cnt           <= '0;
      end else begin
         adc_capture_en_o <= en_nxt;
         busy_o           <= busy_nxt;
         done_o           <= done_nxt;
         trig_prev        <= trig_i;
         gap_cnt          <= (state == GAP) ? gap_cnt + GAP_W'(1) : '0;
         wd_cnt           <= (state == CAPTURE && !beat) ? wd_cnt + TMO_W'(1) : '0;
         if (state == IDLE && start_i) begin
            frames      <= (cfg_frames_i == '0) ? FRM_W'(1) : cfg_frames_i;
            length_o    <= cfg_length_i;
            gap         <= cfg_gap_i;
            tmo         <= cfg_tmo_i;
            trig_en     <= cfg_trig_en_i;
            frame_cnt_o <= '0;
            timeout_o   <= 1'b0;
         end else if (state == CAPTURE && !abort_i) begin
            if (wd_fire)  timeout_o   <= 1'b1;
            else if (eop) frame_cnt_o <= cnt_inc;
         end
      end
   end

endmodule

// File: tb/tb_adc_capture_sequencer.sv
// Bench for adc_capture_sequencer: table of free-run runs plus hand-written trigger, watchdog, abort and reset sequences.
module tb_adc_capture_sequencer;

   logic        clk_i, reset_ni, start_i, abort_i, trig_i, cfg_trig_en_i;
   logic [15:0] cfg_frames_i, cfg_gap_i, frame_cnt_o;
   logic [31:0] cfg_length_i, length_o;
   logic [23:0] cfg_tmo_i;
   logic        mon_tvalid_i, mon_tready_i, mon_tlast_i;
   logic        adc_capture_en_o, busy_o, done_o, timeout_o;

   int total = 0;
   int bad = 0;
   int done_seen = 0;
   int exp_q[$];

   typedef struct {
      logic [15:0] frames;
      logic [15:0] gap;
      logic [31:0] len;
      int          beats;
      int          exp_frames;
   } row_t;

   row_t rows[3];

   adc_capture_sequencer dut (
      .clk_i(clk_i), .reset_ni(reset_ni), .start_i(start_i), .abort_i(abort_i),
      .trig_i(trig_i), .cfg_trig_en_i(cfg_trig_en_i), .cfg_frames_i(cfg_frames_i),
      .cfg_length_i(cfg_length_i), .cfg_gap_i(cfg_gap_i), .cfg_tmo_i(cfg_tmo_i),
      .mon_tvalid_i(mon_tvalid_i), .mon_tready_i(mon_tready_i), .mon_tlast_i(mon_tlast_i),
      .adc_capture_en_o(adc_capture_en_o), .length_o(length_o), .busy_o(busy_o),
      .done_o(done_o), .timeout_o(timeout_o), .frame_cnt_o(frame_cnt_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   always @(negedge clk_i) if (done_o) done_seen++;

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, got hang expected finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic pulse_start();
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
   endtask

   // Counts cycles (starting at 1 for the current one) until capture enable is seen, bounded.
   task automatic wait_en(output int n);
      n = 1;
      while (!adc_capture_en_o && n < 60) begin
         tick();
         n++;
      end
   endtask

   task automatic run_row(input row_t r);
      int n;
      cfg_trig_en_i = 1'b0;
      cfg_frames_i  = r.frames;
      cfg_gap_i     = r.gap;
      cfg_length_i  = r.len;
      cfg_tmo_i     = '0;
      pulse_start();
      cfg_frames_i = 16'd1;
      cfg_gap_i    = 16'd9;
      cfg_length_i = 32'hDEAD_BEEF;
      cfg_tmo_i    = 24'd3;
      chk("row_busy", 32'(busy_o), 32'd1);
      for (int f = 0; f < r.exp_frames; f++) begin
         wait_en(n);
         chk("row_en_latency", 32'(n), (f == 0) ? 32'd2 : 32'(r.gap) + 32'd2);
         for (int b = 0; b < r.beats; b++) begin
            mon_tvalid_i = 1'b1;
            mon_tready_i = 1'b1;
            mon_tlast_i  = (b == r.beats - 1);
            if (b == 0) start_i = 1'b1;
            if (b == r.beats - 1) exp_q.push_back(f + 1);
            tick();
            start_i = 1'b0;
            if (b == 0) chk("row_en_drop", 32'(adc_capture_en_o), 32'd0);
         end
         mon_tvalid_i = 1'b0;
         mon_tlast_i  = 1'b0;
         chk("row_frame_cnt", 32'(frame_cnt_o), 32'(exp_q.pop_front()));
         chk("row_done", 32'(done_o), (f == r.exp_frames - 1) ? 32'd1 : 32'd0);
      end
      tick();
      chk("row_done_end", 32'(done_o), 32'd0);
      chk("row_busy_end", 32'(busy_o), 32'd0);
      chk("row_length", length_o, r.len);
      chk("row_frame_final", 32'(frame_cnt_o), 32'(r.exp_frames));
   endtask

   initial begin
      int n;
      rows[0] = '{frames: 16'd3, gap: 16'd4, len: 32'd15, beats: 16, exp_frames: 3};
      rows[1] = '{frames: 16'd0, gap: 16'd5, len: 32'h1234, beats: 1, exp_frames: 1};
      rows[2] = '{frames: 16'd2, gap: 16'd0, len: 32'd7, beats: 3, exp_frames: 2};

      reset_ni = 1'b0; start_i = 1'b0; abort_i = 1'b0; trig_i = 1'b0; cfg_trig_en_i = 1'b0;
      cfg_frames_i = '0; cfg_gap_i = '0; cfg_length_i = '0; cfg_tmo_i = '0;
      mon_tvalid_i = 1'b0; mon_tready_i = 1'b1; mon_tlast_i = 1'b0;
      repeat (3) tick();
      chk("rst_en", 32'(adc_capture_en_o), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_done", 32'(done_o), 32'd0);
      chk("rst_timeout", 32'(timeout_o), 32'd0);
      chk("rst_frame_cnt", 32'(frame_cnt_o), 32'd0);
      chk("rst_length", length_o, 32'd0);
      reset_ni = 1'b1;
      repeat (2) tick();

      for (int i = 0; i < 3; i++) begin
         run_row(rows[i]);
         repeat (2) tick();
      end

      // Trigger held high at arm must not fire; the following rising edge must.
      cfg_trig_en_i = 1'b1; cfg_frames_i = 16'd1; cfg_gap_i = '0; cfg_length_i = 32'd5; cfg_tmo_i = '0;
      trig_i = 1'b1;
      tick();
      pulse_start();
      repeat (4) tick();
      chk("trig_hold_en", 32'(adc_capture_en_o), 32'd0);
      chk("trig_hold_busy", 32'(busy_o), 32'd1);
      trig_i = 1'b0;
      tick();
      trig_i = 1'b1;
      chk("trig_edge_cycle_en", 32'(adc_capture_en_o), 32'd0);
      tick();
      chk("trig_next_cycle_en", 32'(adc_capture_en_o), 32'd1);
      mon_tvalid_i = 1'b1; mon_tready_i = 1'b1; mon_tlast_i = 1'b1;
      exp_q.push_back(1);
      tick();
      mon_tvalid_i = 1'b0; mon_tlast_i = 1'b0;
      chk("trig_frame_cnt", 32'(frame_cnt_o), 32'(exp_q.pop_front()));
      chk("trig_done", 32'(done_o), 32'd1);
      trig_i = 1'b0;
      repeat (2) tick();

      // Watchdog: stall tready after five beats.
      cfg_trig_en_i = 1'b0; cfg_frames_i = 16'd1; cfg_tmo_i = 24'd100; cfg_length_i = 32'd9;
      pulse_start();
      wait_en(n);
      chk("tmo_en_latency", 32'(n), 32'd2);
      repeat (5) begin
         mon_tvalid_i = 1'b1; mon_tready_i = 1'b1;
         tick();
      end
      mon_tready_i = 1'b0;
      repeat (99) tick();
      chk("tmo_before", 32'(timeout_o), 32'd0);
      chk("tmo_before_busy", 32'(busy_o), 32'd1);
      tick();
      chk("tmo_fire", 32'(timeout_o), 32'd1);
      chk("tmo_busy", 32'(busy_o), 32'd0);
      chk("tmo_en", 32'(adc_capture_en_o), 32'd0);
      mon_tvalid_i = 1'b0; mon_tready_i = 1'b1;
      tick();
      chk("tmo_sticky", 32'(timeout_o), 32'd1);

      // Abort in the gap after the first of four frames; start also clears the sticky timeout.
      n = done_seen;
      cfg_frames_i = 16'd4; cfg_gap_i = 16'd6; cfg_tmo_i = '0; cfg_length_i = 32'd3;
      pulse_start();
      chk("tmo_cleared", 32'(timeout_o), 32'd0);
      begin
         int lat;
         wait_en(lat);
         chk("abort_en_latency", 32'(lat), 32'd2);
      end
      mon_tvalid_i = 1'b1; mon_tready_i = 1'b1; mon_tlast_i = 1'b0;
      tick();
      mon_tlast_i = 1'b1;
      exp_q.push_back(1);
      tick();
      mon_tvalid_i = 1'b0; mon_tlast_i = 1'b0;
      chk("abort_frame_cnt", 32'(frame_cnt_o), 32'(exp_q.pop_front()));
      tick();
      abort_i = 1'b1;
      tick();
      abort_i = 1'b0;
      chk("abort_busy", 32'(busy_o), 32'd0);
      chk("abort_en", 32'(adc_capture_en_o), 32'd0);
      chk("abort_frame_hold", 32'(frame_cnt_o), 32'd1);
      repeat (10) tick();
      chk("abort_no_done", 32'(done_seen), 32'(n));
      chk("abort_en_stays", 32'(adc_capture_en_o), 32'd0);

      // Asynchronous reset in the middle of the second frame's capture.
      cfg_frames_i = 16'd2; cfg_gap_i = 16'd2; cfg_length_i = 32'h77;
      pulse_start();
      begin
         int lat;
         wait_en(lat);
         mon_tvalid_i = 1'b1; mon_tready_i = 1'b1; mon_tlast_i = 1'b1;
         tick();
         mon_tvalid_i = 1'b0; mon_tlast_i = 1'b0;
         chk("rstmid_frame_cnt", 32'(frame_cnt_o), 32'd1);
         wait_en(lat);
         chk("rstmid_en_latency", 32'(lat), 32'd4);
      end
      mon_tvalid_i = 1'b1; mon_tready_i = 1'b1;
      tick();
      mon_tvalid_i = 1'b0;
      #2;
      reset_ni = 1'b0;
      #1;
      chk("rstmid_en", 32'(adc_capture_en_o), 32'd0);
      chk("rstmid_busy", 32'(busy_o), 32'd0);
      chk("rstmid_cnt", 32'(frame_cnt_o), 32'd0);
      chk("rstmid_length", length_o, 32'd0);
      chk("rstmid_done", 32'(done_o), 32'd0);
      repeat (2) tick();
      reset_ni = 1'b1;
      repeat (2) tick();
      chk("rstmid_idle_busy", 32'(busy_o), 32'd0);

      chk("done_pulses", 32'(done_seen), 32'd4);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
